mdu_iter: RTL



---
 rtl/mdu_iter_if.sv | 24 ++
 rtl/mdu_iter.sv | 127 ++++++++++++
 2 files changed

// File: rtl/mdu_iter_if.sv
// Issue/result bundle between the EX-stage control and the iterative multiply/divide unit.
interface mdu_iter_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cancel;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, cancel,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, a, b, cancel,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mdu_iter.sv
// Iterative radix-2 multiply/divide unit with HI/LO registers: shift-add multiply,
// restoring divide, both on magnitudes with a final sign-correction cycle.
module mdu_iter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input  logic      clk,
  input  logic      rst,
  mdu_iter_if.slave io_mdu
);

  typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

  state_e             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_opb;
  logic [WIDTH-1:0]   r_hi, r_lo;
  logic               r_is_div, r_neg_q, r_neg_r, r_done;

  logic               w_issue, w_md_op, w_signed, w_a_neg, w_b_neg;
  logic [WIDTH-1:0]   w_a_mag, w_b_mag;
  logic [WIDTH:0]     w_sum, w_shift, w_diff;
  logic [2*WIDTH-1:0] w_mul_nxt, w_div_nxt, w_prod;
  logic [WIDTH-1:0]   w_quo, w_rem, w_fix_hi, w_fix_lo;

  assign w_issue  = (r_state == StIdle) && io_mdu.start && !io_mdu.cancel;
  assign w_md_op  = !io_mdu.op[2];
  assign w_signed = !io_mdu.op[0];
  assign w_a_neg  = w_signed && io_mdu.a[WIDTH-1];
  assign w_b_neg  = w_signed && io_mdu.b[WIDTH-1];
  assign w_a_mag  = w_a_neg ? -io_mdu.a : io_mdu.a;
  assign w_b_mag  = w_b_neg ? -io_mdu.b : io_mdu.b;

  // Multiply: upper half accumulates, lower half holds the multiplier shifting out.
  assign w_sum     = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, (r_acc[0] ? r_opb : '0)};
  assign w_mul_nxt = {w_sum, r_acc[WIDTH-1:1]};

  // Divide: upper half is the partial remainder, lower half the dividend/quotient.
  assign w_shift   = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
  assign w_diff    = w_shift - {1'b0, r_opb};
  assign w_div_nxt = w_diff[WIDTH] ? {w_shift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                                   : {w_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};

  assign w_prod   = r_neg_q ? -r_acc : r_acc;
  assign w_quo    = r_acc[WIDTH-1:0];
  assign w_rem    = r_acc[2*WIDTH-1:WIDTH];
  assign w_fix_hi = r_is_div ? (r_neg_r ? -w_rem : w_rem) : w_prod[2*WIDTH-1:WIDTH];
  assign w_fix_lo = r_is_div ? (r_neg_q ? -w_quo : w_quo) : w_prod[WIDTH-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= StIdle;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle:  if (w_issue && w_md_op) w_state_nxt = StCalc;
      StCalc: begin
        if (io_mdu.cancel)      w_state_nxt = StIdle;
        else if (r_cnt == '0)   w_state_nxt = StFix;
      end
      StFix:   w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  always_comb begin
    io_mdu.busy = (r_state != StIdle);
    io_mdu.done = r_done;
    io_mdu.hi   = r_hi;
    io_mdu.lo   = r_lo;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= '0;
      r_acc    <= '0;
      r_opb    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= (r_state == StFix) && !io_mdu.cancel;
      case (r_state)
        StIdle: begin
          if (w_issue && w_md_op) begin
            r_cnt    <= CNT_W'(WIDTH - 1);
            r_is_div <= io_mdu.op[1];
            if (io_mdu.op[1]) begin
              r_acc   <= {{WIDTH{1'b0}}, w_a_mag};
              r_opb   <= w_b_mag;
              // Divide by zero keeps the raw all-ones quotient unsigned.
              r_neg_q <= (w_a_neg ^ w_b_neg) && (io_mdu.b != '0);
              r_neg_r <= w_a_neg;
            end else begin
              r_acc   <= {{WIDTH{1'b0}}, w_b_mag};
              r_opb   <= w_a_mag;
              r_neg_q <= w_a_neg ^ w_b_neg;
              r_neg_r <= 1'b0;
            end
          end else if (w_issue && io_mdu.op == 3'd4) begin
            r_hi <= io_mdu.a;
          end else if (w_issue && io_mdu.op == 3'd5) begin
            r_lo <= io_mdu.a;
          end
        end
        StCalc: begin
          r_acc <= r_is_div ? w_div_nxt : w_mul_nxt;
          r_cnt <= r_cnt - CNT_W'(1);
        end
        StFix: begin
          if (!io_mdu.cancel) begin
            r_hi <= w_fix_hi;
            r_lo <= w_fix_lo;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
